// File: rtl/block_data_memory.sv
// ---------------------------------------------------------------------------
// block_data_memory
//
// Main-memory model placed directly behind the data cache. It serves
// 128-bit (4 x 32-bit word) block reads and write-backs with a fixed access
// latency. Only one request is outstanding at a time. The request is
// captured when it is accepted, so the cache may change its outputs while the
// access is in progress.
//
// Ports:
//   clock      in   rising-edge system clock
//   reset      in   asynchronous, active-low reset
//   read       in   block read request
//   write      in   block write request (wins over read when both are high)
//   address    in   block address; only [INDEX_W-1:0] used (upper bits alias)
//   writedata  in   block to write; word0 = [31:0] ... word3 = [127:96]
//   readdata   out  last block read, registered, held until the next read
//   busywait   out  high while a request is pending or in progress
//
// Optional feature (macro DMEM_STATS_EN):
//   read_count  out  completed reads, wraps at 2**32
//   write_count out  completed writes (a dual request counts as a write)
// ---------------------------------------------------------------------------
module block_data_memory #(
    parameter int ADDR_W  = 28,
    parameter int INDEX_W = 8,
    parameter int LATENCY = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [127:0]      writedata,
    output logic [127:0]      readdata,
    output logic              busywait
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       read_count,
    output logic [31:0]       write_count
`endif
);

    localparam int DATA_W = 128;
    localparam int DEPTH  = 1 << INDEX_W;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [INDEX_W-1:0]  idx_p0;
    logic [DATA_W-1:0]   data_p0;
    logic                is_write_p0;
    logic                finish;

    // Storage is deliberately not reset; contents are undefined until written.
    logic [DATA_W-1:0]   mem [DEPTH];

    // Upper address bits are ignored on purpose (aliasing onto the array).
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[ADDR_W-1:INDEX_W];

    // The latched operation takes effect on the last ACCESS edge.
    assign finish = (state == ACCESS) && (count == '0);

    // In IDLE busywait follows the request combinationally so the cache sees
    // it in the same cycle it raises read/write.
    always_comb begin
        busywait = 1'b0;
        case (state)
            IDLE:    busywait = read | write;
            ACCESS:  busywait = 1'b1;
            default: busywait = 1'b0;
        endcase
    end

    // Accept -> ACCESS (LATENCY cycles) -> DONE (one cycle) -> IDLE
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            idx_p0      <= '0;
            data_p0     <= '0;
            is_write_p0 <= 1'b0;
            readdata    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (read | write) begin
                        idx_p0      <= address[INDEX_W-1:0];
                        data_p0     <= writedata;
                        is_write_p0 <= write;  // dual request performs the write
                        count       <= CNT_LOAD;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        if (!is_write_p0) begin
                            readdata <= mem[idx_p0];
                        end
                        state <= DONE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Reset forces the FSM to IDLE asynchronously, so an aborted write never
    // reaches the array.
    always_ff @(posedge clock) begin
        if (finish && is_write_p0) begin
            mem[idx_p0] <= data_p0;
        end
    end

`ifdef DMEM_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_count  <= '0;
            write_count <= '0;
        end else if (finish) begin
            if (is_write_p0) begin
                write_count <= write_count + 32'd1;
            end else begin
                read_count  <= read_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_block_data_memory.sv
module tb_block_data_memory;

    localparam int ADDR_W  = 28;
    localparam int INDEX_W = 8;
    localparam int LATENCY = 5;
    localparam int DEPTH   = 1 << INDEX_W;
    localparam int TMO     = 100;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              read  = 1'b0;
    logic              write = 1'b0;
    logic [ADDR_W-1:0] address   = '0;
    logic [127:0]      writedata = '0;
    logic [127:0]      readdata;
    logic              busywait;
`ifdef DMEM_STATS_EN
    logic [31:0]       read_count;
    logic [31:0]       write_count;
`endif

    always #5 clock = ~clock;

    block_data_memory #(
        .ADDR_W (ADDR_W),
        .INDEX_W(INDEX_W),
        .LATENCY(LATENCY)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .busywait   (busywait)
`ifdef DMEM_STATS_EN
        ,
        .read_count (read_count),
        .write_count(write_count)
`endif
    );

    // One entry per issued request: what the DONE cycle must show.
    typedef struct {
        bit           is_read;  // pure read (dual requests are writes)
        bit           chk;      // read data known to the model
        logic [127:0] data;
    } exp_t;

    exp_t         sb[$];
    int           errors   = 0;
    int           checks   = 0;
    int           done_cnt = 0;

    // Reference memory: plain array of blocks plus a written flag.
    logic [127:0] mem_model [DEPTH];
    bit           known     [DEPTH];

    task automatic check128(input string name, input logic [127:0] act,
                            input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    int           run       = 0;
    bit           prev_busy = 0;
    logic [127:0] held_val  = '0;
    bit           held_known = 1;

    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            check128("reset_busywait", {127'b0, busywait}, 128'd0);
            check128("reset_readdata", readdata, 128'd0);
            prev_busy  = 0;
            run        = 0;
            held_val   = '0;
            held_known = 1;
        end else if (busywait) begin
            run++;
            prev_busy = 1;
        end else if (prev_busy) begin
            // DONE cycle: busywait just fell
            check128("busy_len", 128'(run), 128'(LATENCY + 1));
            if (sb.size() == 0) begin
                check128("unexpected_done", 128'd1, 128'd0);
            end else begin
                e = sb.pop_front();
                if (e.is_read) begin
                    if (e.chk) begin
                        check128("read_data", readdata, e.data);
                        held_val   = e.data;
                        held_known = 1;
                    end else begin
                        held_known = 0;
                    end
                end else if (held_known) begin
                    check128("write_keeps_readdata", readdata, held_val);
                end
            end
            done_cnt++;
            prev_busy = 0;
            run       = 0;
        end else if (held_known) begin
            check128("readdata_held", readdata, held_val);
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_done(input int start);
        int n;
        n = 0;
        while (done_cnt == start && n < TMO) begin
            @(negedge clock); #1;
            n++;
        end
        if (done_cnt == start) begin
            check128("done_timeout", 128'd0, 128'd1);
        end
    endtask

    // Called one step after a rising edge with the DUT idle.
    task automatic do_op(input bit rd, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [127:0] d, input int hold);
        int   idx;
        int   start;
        exp_t e;
        idx       = int'(a[INDEX_W-1:0]);
        e.is_read = rd && !wr;
        e.chk     = 0;
        e.data    = '0;
        if (wr) begin
            mem_model[idx] = d;
            known[idx]     = 1;
        end else begin
            e.chk  = known[idx];
            e.data = mem_model[idx];
        end
        sb.push_back(e);
        start     = done_cnt;
        read      = rd;
        write     = wr;
        address   = a;
        writedata = d;
        @(posedge clock); #1;
        // request is latched: scramble the buses, keep the strobe a while
        address   = ADDR_W'($urandom);
        writedata = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
        end
        read  = 0;
        write = 0;
        wait_done(start);
        @(posedge clock); #1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            known[i]     = 0;
            mem_model[i] = '0;
        end
        reset = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1;
        @(posedge clock); #1;

        // read of an unwritten block: timing only
        do_op(1, 0, 28'h0000003, '0, LATENCY - 1);

        // write then read the same block, back to back
        do_op(0, 1, 28'h0000005, 128'h44443333222211110000FFFFDEADBEEF, 0);
        do_op(1, 0, 28'h0000005, '0, 0);
        repeat (3) @(posedge clock);
        #1;

        // aliasing: upper address bits ignored
        do_op(0, 1, 28'h0000105, {16{8'hA5}}, 1);
        do_op(1, 0, 28'h0000005, '0, 2);

        // dual request performs only the write
        do_op(1, 1, 28'h0000007, {32{4'h1}}, 0);
        do_op(1, 0, 28'h0000007, '0, 0);

        // request dropped after one ACCESS cycle still completes
        do_op(1, 0, 28'h0000005, '0, 1);

        // reset in the third ACCESS cycle aborts a write
        do_op(0, 1, 28'h0000009, 128'h0123456789ABCDEF_FEDCBA9876543210, 0);
        read      = 0;
        write     = 1;
        address   = 28'h0000009;
        writedata = '1;
        @(posedge clock); #1;  // accepted
        write = 0;
        @(posedge clock); #1;
        @(posedge clock); #1;  // third ACCESS cycle
        reset = 0;
        sb.delete();
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        do_op(1, 0, 28'h0000009, '0, 0);

        // randomized traffic over a small index range
        for (int n = 0; n < 40; n++) begin
            int               op;
            logic [ADDR_W-1:0] a;
            op = int'($urandom_range(0, 3));
            a  = ADDR_W'($urandom);
            a[INDEX_W-1:0] = INDEX_W'($urandom_range(0, 15));
            do_op(op < 2, op >= 2, a,
                  {$urandom, $urandom, $urandom, $urandom},
                  int'($urandom_range(0, LATENCY - 1)));
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #1;
        end

`ifdef DMEM_STATS_EN
        reset = 0;
        @(posedge clock); #1;
        reset = 1;
        @(posedge clock); #1;
        do_op(1, 0, 28'h0000005, '0, 0);
        do_op(0, 1, 28'h0000020, 128'hCAFE, 0);
        do_op(1, 0, 28'h0000020, '0, 0);
        do_op(0, 1, 28'h0000021, 128'hBEEF, 0);
        do_op(1, 1, 28'h0000022, 128'hF00D, 0);
        do_op(1, 0, 28'h0000022, '0, 0);
        check128("read_count", {96'b0, read_count}, 128'd3);
        check128("write_count", {96'b0, write_count}, 128'd3);
`endif

        repeat (2) @(posedge clock);
        #1;
        check128("scoreboard_empty", 128'(sb.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
